// File: rtl/t_flip_flop.sv
`default_nettype none
// ----------------------------------------------------------------------------
// t_flip_flop : bank of WIDTH toggle flip-flops with true/complement outputs.
// Optional clock enable port ce when TFF_CLK_ENABLE_EN is defined. Rev 1.0
// ----------------------------------------------------------------------------
module t_flip_flop #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
`ifdef TFF_CLK_ENABLE_EN
  input  logic             ce,
`endif
  input  logic [WIDTH-1:0] T,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] w_toggle;

`ifdef TFF_CLK_ENABLE_EN
  always_comb begin
    w_toggle = '0;
    if (ce) w_toggle = T;
  end
`else
  always_comb begin
    w_toggle = T;
  end
`endif

  always_comb begin
    q_d = q_q ^ w_toggle;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q_q <= RESET_VALUE;
    else       q_q <= q_d;
  end

  // qbar is taken from the same register so it can never disagree with q.
  assign q    = q_q;
  assign qbar = ~q_q;

endmodule
`default_nettype wire

// File: tb/tb_t_flip_flop.sv
`default_nettype none
// Directed bench for t_flip_flop: a 1-bit and a 4-bit instance on one clock.
module tb_t_flip_flop;

  logic       clk = 1'b0;
  logic       rst1, rst4;
  logic       t1;
  logic [3:0] t4;
  logic       q1, qb1;
  logic [3:0] q4, qb4;
  int         total = 0;
  int         bad   = 0;
`ifdef TFF_CLK_ENABLE_EN
  logic       ce;
`endif

  always #5 clk = ~clk;

  t_flip_flop #(.WIDTH(1), .RESET_VALUE(1'b0)) u_dut1 (
    .clk   (clk),
    .reset (rst1),
`ifdef TFF_CLK_ENABLE_EN
    .ce    (ce),
`endif
    .T     (t1),
    .q     (q1),
    .qbar  (qb1)
  );

  t_flip_flop #(.WIDTH(4), .RESET_VALUE(4'b0000)) u_dut4 (
    .clk   (clk),
    .reset (rst4),
`ifdef TFF_CLK_ENABLE_EN
    .ce    (ce),
`endif
    .T     (t4),
    .q     (q4),
    .qbar  (qb4)
  );

  task automatic test_reset();
    #1;
    total++; if (q1 !== 1'b0) begin bad++; $display("FAIL reset_q1: got %b want 0", q1); end
    total++; if (qb1 !== 1'b1) begin bad++; $display("FAIL reset_qb1: got %b want 1", qb1); end
    total++; if (q4 !== 4'b0000) begin bad++; $display("FAIL reset_q4: got %b want 0000", q4); end
    total++; if (qb4 !== 4'b1111) begin bad++; $display("FAIL reset_qb4: got %b want 1111", qb4); end
    t1 = 1'b1;
    @(posedge clk); #1;
    total++; if (q1 !== 1'b0) begin bad++; $display("FAIL reset_edge_q1: got %b want 0", q1); end
  endtask

  task automatic test_hold();
    @(negedge clk);
    rst1 = 1'b0; t1 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      total++; if (q1 !== 1'b0) begin bad++; $display("FAIL hold_q1[%0d]: got %b want 0", i, q1); end
      total++; if (qb1 !== 1'b1) begin bad++; $display("FAIL hold_qb1[%0d]: got %b want 1", i, qb1); end
    end
  endtask

  task automatic test_toggle();
    logic [2:0] exp_seq;
    exp_seq = 3'b101;
    @(negedge clk);
    t1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++; if (q1 !== exp_seq[2-i]) begin bad++; $display("FAIL toggle_q1[%0d]: got %b want %b", i, q1, exp_seq[2-i]); end
      total++; if (qb1 !== ~exp_seq[2-i]) begin bad++; $display("FAIL toggle_qb1[%0d]: got %b want %b", i, qb1, ~exp_seq[2-i]); end
    end
  endtask

  task automatic test_async_reset();
    // q1 is 1 and T stays 1; reset lands between edges.
    @(negedge clk); #2;
    rst1 = 1'b1;
    #1;
    total++; if (q1 !== 1'b0) begin bad++; $display("FAIL async_q1: got %b want 0", q1); end
    total++; if (qb1 !== 1'b1) begin bad++; $display("FAIL async_qb1: got %b want 1", qb1); end
    @(posedge clk); #1;
    total++; if (q1 !== 1'b0) begin bad++; $display("FAIL async_held_q1: got %b want 0", q1); end
    @(negedge clk);
    rst1 = 1'b0;
    @(posedge clk); #1;
    total++; if (q1 !== 1'b1) begin bad++; $display("FAIL release_q1: got %b want 1", q1); end
  endtask

  task automatic test_between_edges();
    @(negedge clk);
    t1 = 1'b0;
    #1 t1 = 1'b1;
    #2 t1 = 1'b0;
    @(posedge clk); #1;
    total++; if (q1 !== 1'b1) begin bad++; $display("FAIL glitch_q1: got %b want 1", q1); end
  endtask

  task automatic test_multibit();
    logic [3:0] tv [3];
    logic [3:0] qv [3];
    tv[0] = 4'b1010; qv[0] = 4'b1010;
    tv[1] = 4'b0110; qv[1] = 4'b1100;
    tv[2] = 4'b1111; qv[2] = 4'b0011;
    @(negedge clk);
    rst4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      t4 = tv[i];
      @(posedge clk); #1;
      total++; if (q4 !== qv[i]) begin bad++; $display("FAIL multi_q4[%0d]: got %b want %b", i, q4, qv[i]); end
      total++; if (qb4 !== ~qv[i]) begin bad++; $display("FAIL multi_qb4[%0d]: got %b want %b", i, qb4, ~qv[i]); end
      @(negedge clk);
    end
    t4 = 4'b0000;
    @(posedge clk); #1;
    total++; if (q4 !== 4'b0011) begin bad++; $display("FAIL multi_hold_q4: got %b want 0011", q4); end
  endtask

`ifdef TFF_CLK_ENABLE_EN
  task automatic test_clock_enable();
    // q1 is 1 on entry.
    @(negedge clk);
    ce = 1'b0; t1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++; if (q1 !== 1'b1) begin bad++; $display("FAIL ce0_q1[%0d]: got %b want 1", i, q1); end
    end
    @(negedge clk);
    ce = 1'b1;
    @(posedge clk); #1;
    total++; if (q1 !== 1'b0) begin bad++; $display("FAIL ce1_q1: got %b want 0", q1); end
    @(posedge clk); #1;
    total++; if (q1 !== 1'b1) begin bad++; $display("FAIL ce1b_q1: got %b want 1", q1); end
    @(negedge clk);
    ce = 1'b0;
    #1 rst1 = 1'b1;
    #1;
    total++; if (q1 !== 1'b0) begin bad++; $display("FAIL ce0_reset_q1: got %b want 0", q1); end
    @(negedge clk);
    rst1 = 1'b0; ce = 1'b1;
  endtask
`endif

  initial begin
    rst1 = 1'b1; rst4 = 1'b1;
    t1 = 1'b0; t4 = 4'b0000;
`ifdef TFF_CLK_ENABLE_EN
    ce = 1'b1;
`endif
    test_reset();
    test_hold();
    test_toggle();
    test_async_reset();
    test_between_edges();
    test_multibit();
`ifdef TFF_CLK_ENABLE_EN
    test_clock_enable();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
